// File: rtl/encoder_cpu.sv
// encoder_cpu: packs CPU instruction fields into 32-bit code words, buffers
// them in a DEPTH-entry FIFO and presents them with a running program address.
// Optional macro ENC_OPCODE_CHECK_EN: drop field sets whose opcode is
// >= NUM_OPS and raise a sticky err flag; otherwise err is tied low.
module encoder_cpu #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 8,
  parameter int NUM_OPS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_en,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      fmt,
  input  logic [5:0]                opcode_cpu,
  input  logic [1:0]                func_cpu,
  input  logic [23:0]               addr_cpu,
  input  logic [7:0]                imm_cpu,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               code,
  output logic [ADDR_W-1:0]         prog_addr,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [31:0]       word;
  logic              accept, illegal, push, pop;

  // Address format carries a 24-bit target; immediate format zero-fills the top.
  assign word = fmt ? {16'h0000, imm_cpu, opcode_cpu, func_cpu}
                    : {addr_cpu, opcode_cpu, func_cpu};

  // in_ready is held low during reset even if en_en is already high.
  assign in_ready  = rst_n & en_en & (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign code      = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign prog_addr = prog_addr_q;
  assign count     = count_q;
  assign accept    = in_valid & in_ready;

`ifdef ENC_OPCODE_CHECK_EN
  logic err_q, err_d;

  assign illegal = (32'(opcode_cpu) >= 32'(NUM_OPS));
  assign err     = err_q;

  // Sticky illegal-opcode flag; only clr or reset clears it.
  always_comb begin
    err_d = err_q;
    if (clr)                    err_d = 1'b0;
    else if (accept && illegal) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  // clr swallows any same-cycle push or pop.
  assign push = accept & ~illegal & ~clr;
  assign pop  = out_valid & out_ready & ~clr;

  // Next-state for pointers, occupancy and program address.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    prog_addr_d = prog_addr_q;
    if (clr) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      prog_addr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        prog_addr_d = prog_addr_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      prog_addr_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      prog_addr_q <= prog_addr_d;
    end
  end

  // Storage needs no reset: count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

endmodule

// File: tb/tb_encoder_cpu.sv
// tb_encoder_cpu: directed stimulus against a queue-based reference model,
// compared every cycle, plus hand-computed literal checks.
module tb_encoder_cpu;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 8;
  localparam int NUM_OPS = 16;
`ifdef ENC_OPCODE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en_en, clr, in_valid, out_ready, fmt;
  logic [5:0]  opcode_cpu;
  logic [1:0]  func_cpu;
  logic [23:0] addr_cpu;
  logic [7:0]  imm_cpu;
  logic        in_ready, out_valid, err;
  logic [31:0] code;
  logic [ADDR_W-1:0] prog_addr;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  encoder_cpu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_OPS(NUM_OPS)) dut (
    .clk(clk), .rst_n(rst_n), .en_en(en_en), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .opcode_cpu(opcode_cpu), .func_cpu(func_cpu), .addr_cpu(addr_cpu),
    .imm_cpu(imm_cpu), .out_valid(out_valid), .out_ready(out_ready),
    .code(code), .prog_addr(prog_addr), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]       mq[$];
  logic [ADDR_W-1:0] m_pa  = '0;
  logic              m_err = 1'b0;

  function automatic logic [31:0] pack(input logic f, input logic [5:0] op,
                                       input logic [1:0] fn, input logic [23:0] a,
                                       input logic [7:0] im);
    if (f) return {16'h0000, im, op, fn};
    return {a, op, fn};
  endfunction

  function automatic bit bad_op(input logic [5:0] op);
    return CHK_EN && (int'(op) >= NUM_OPS);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      mq.delete();
      m_pa  <= '0;
      m_err <= 1'b0;
    end else begin
      if (in_valid && en_en && mq.size() < DEPTH && bad_op(opcode_cpu)) m_err <= 1'b1;
      if (out_ready && mq.size() != 0) begin
        void'(mq.pop_front());
        m_pa <= m_pa + 1'b1;
      end
      // Readiness is judged on the pre-pop occupancy (no bypass).
      if (in_valid && en_en && (mq.size() + ((out_ready && mq.size() != 0) ? 1 : 0)) < DEPTH
          && !bad_op(opcode_cpu))
        mq.push_back(pack(fmt, opcode_cpu, func_cpu, addr_cpu, imm_cpu));
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("in_ready", {31'b0, in_ready}, {31'b0, (rst_n && en_en && mq.size() < DEPTH)});
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    chk("count", 32'(count), 32'(mq.size()));
    chk("prog_addr", 32'(prog_addr), 32'(m_pa));
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (mq.size() != 0) chk("code", code, mq[0]);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic f, input logic [5:0] op, input logic [1:0] fn,
                          input logic [23:0] a, input logic [7:0] im);
    fmt = f; opcode_cpu = op; func_cpu = fn; addr_cpu = a; imm_cpu = im;
  endtask

  initial begin
    rst_n = 1'b0; en_en = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_word(1'b0, 6'h0, 2'b0, 24'h0, 8'h0);
    cyc(); cyc();
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_code", code, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_prog_addr", 32'(prog_addr), 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'h1);

    // Address format, single word, one-cycle latency.
    cyc();
    set_word(1'b0, 6'h00, 2'b00, 24'h000102, 8'h00);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t1_out_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_code", code, 32'h00010200);
    chk("t1_prog_addr", 32'(prog_addr), 32'h0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t1_pa_after", 32'(prog_addr), 32'h1);
    chk("t1_count_after", 32'(count), 32'h0);

    // Immediate format ignores the address field.
    set_word(1'b1, 6'h03, 2'b01, 24'hFFFFFF, 8'hA5);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t2_code", code, 32'h0000A50D);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Fill to full, hold a fifth request, then push+pop at count=2.
    for (int i = 0; i < 4; i++) begin
      set_word(i[0], 6'(i + 1), 2'(i), 24'(24'h100000 + i), 8'(8'h10 + i));
      in_valid = 1'b1;
      cyc();
    end
    chk("t3_count_full", 32'(count), 32'h4);
    chk("t3_in_ready_full", {31'b0, in_ready}, 32'h0);
    set_word(1'b0, 6'h0F, 2'b11, 24'hABCDEF, 8'h00);
    cyc(); cyc();
    chk("t3_count_held", 32'(count), 32'h4);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    chk("t3_count_two", 32'(count), 32'h2);
    in_valid = 1'b1;
    cyc();
    chk("t3_count_pushpop", 32'(count), 32'h2);
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("t3_count_drained", 32'(count), 32'h0);
    out_ready = 1'b0;

    // en_en low: no pushes but the output side drains.
    in_valid = 1'b1;
    set_word(1'b1, 6'h05, 2'b10, 24'h0, 8'h5A);
    cyc(); cyc();
    en_en = 1'b0; out_ready = 1'b1;
    #1;
    chk("t4_in_ready_dis", {31'b0, in_ready}, 32'h0);
    cyc(); cyc(); cyc();
    chk("t4_count_drained", 32'(count), 32'h0);
    en_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;

    // clr discards same-cycle push and pop.
    in_valid = 1'b1;
    cyc(); cyc();
    clr = 1'b1; out_ready = 1'b1;
    cyc();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_count_clr", 32'(count), 32'h0);
    chk("t5_pa_clr", 32'(prog_addr), 32'h0);
    chk("t5_out_valid_clr", {31'b0, out_valid}, 32'h0);

    // Out-of-range opcode.
    set_word(1'b0, 6'h20, 2'b01, 24'h123456, 8'h00);
    in_valid = 1'b1;
    #1;
    chk("t6_in_ready", {31'b0, in_ready}, 32'h1);
    cyc();
    in_valid = 1'b0;
`ifdef ENC_OPCODE_CHECK_EN
    chk("t6_count_drop", 32'(count), 32'h0);
    chk("t6_err_set", {31'b0, err}, 32'h1);
`else
    chk("t6_count_kept", 32'(count), 32'h1);
    chk("t6_code", code, 32'h12345681);
    chk("t6_err_tied", {31'b0, err}, 32'h0);
`endif
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t6_err_clr", {31'b0, err}, 32'h0);
    chk("t6_count_clr", 32'(count), 32'h0);
    chk("t6_pa_clr", 32'(prog_addr), 32'h0);

    // Streaming 260 words: prog_addr wraps at 256.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      set_word(i[0], 6'(i % 16), 2'(i), 24'(i * 24'h010203), 8'(i));
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    out_ready = 1'b0;
    chk("t7_pa_wrap", 32'(prog_addr), 32'h4);

    // Asynchronous reset mid-drain.
    in_valid = 1'b1;
    cyc(); cyc(); cyc();
    in_valid = 1'b0;
    chk("t8_count3", 32'(count), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_in_ready", {31'b0, in_ready}, 32'h0);
    chk("t8_out_valid", {31'b0, out_valid}, 32'h0);
    chk("t8_code", code, 32'h0);
    chk("t8_count", 32'(count), 32'h0);
    chk("t8_prog_addr", 32'(prog_addr), 32'h0);
    chk("t8_err", {31'b0, err}, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t8_out_valid_rel", {31'b0, out_valid}, 32'h0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
